// File: rtl/key_debounce.sv
// key_debounce
//   Conditions the raw lock-keypad pins for the row generator. Each raw key
//   is double-flop synchronized, then debounced on its own: the debounced
//   level only flips after the synchronized level has disagreed with it for
//   DB_CYCLES consecutive clocks. An arbitration FSM then passes at most one
//   key through, rejects multi-key presses, and requires every key to be
//   released before it will accept another one (no rollover).
//
// Ports
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset
//   Key_raw  raw key levels, 1 = pressed, asynchronous to clock
//   Key      arbitrated key vector, one-hot or all-zero (registered)
//   Press    one-cycle pulse when a key is accepted (registered)
//   Code     index of the accepted key, 4'hF when none (registered)
//   Jam      high while a multi-key press is being rejected (registered)
//
// Arbitration states
//   state | meaning
//   IDLE  | all keys released, ready to accept a single key
//   HELD  | one key accepted and still held; other keys are ignored
//   JAM   | two or more keys seen from IDLE; wait for all released
//   DRAIN | held key released while others remain; wait for all released

module key_debounce #(
    parameter int N_KEYS    = 12,
    parameter int DB_CYCLES = 20000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_KEYS-1:0] Key_raw,
    output logic [N_KEYS-1:0] Key,
    output logic              Press,
    output logic [3:0]        Code,
    output logic              Jam
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        JAM   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync_a;
    logic [N_KEYS-1:0] sync_b;
    logic [N_KEYS-1:0] d;
    logic [CW-1:0]     cnt [N_KEYS];

    state_t            state;
    state_t            state_nxt;
    logic [N_KEYS-1:0] key_q;
    logic [N_KEYS-1:0] key_nxt;
    logic [3:0]        code_q;
    logic [3:0]        code_nxt;
    logic              press_q;
    logic              press_nxt;
    logic              jam_q;
    logic              jam_nxt;

    logic              one_hot;
    logic              held_hit;
    logic [3:0]        idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= Key_raw;
            sync_b <= sync_a;
        end
    end

    // The counter tracks how long the synchronized level has disagreed with
    // the debounced level; it clears on agreement and on the flip, so it
    // never needs to wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync_b[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    d[i]   <= ~d[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        one_hot  = (d != '0) && ((d & (d - 1'b1)) == '0);
        // key_q is the latched one-hot copy of the accepted key, so masking
        // with it tests d[Code] without an out-of-range index.
        held_hit = |(d & key_q);
        idx      = 4'hF;
        for (int i = 0; i < N_KEYS; i++) begin
            if (d[i]) begin
                idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            key_q   <= '0;
            code_q  <= 4'hF;
            press_q <= 1'b0;
            jam_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            key_q   <= key_nxt;
            code_q  <= code_nxt;
            press_q <= press_nxt;
            jam_q   <= jam_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        code_nxt  = code_q;
        press_nxt = 1'b0;
        jam_nxt   = jam_q;
        case (state)
            IDLE: begin
                key_nxt  = '0;
                code_nxt = 4'hF;
                jam_nxt  = 1'b0;
                if (one_hot) begin
                    state_nxt = HELD;
                    key_nxt   = d;
                    code_nxt  = idx;
                    press_nxt = 1'b1;
                end else if (d != '0) begin
                    state_nxt = JAM;
                    jam_nxt   = 1'b1;
                end
            end
            HELD: begin
                if (!held_hit) begin
                    key_nxt   = '0;
                    code_nxt  = 4'hF;
                    state_nxt = (d == '0) ? IDLE : DRAIN;
                end
            end
            JAM: begin
                key_nxt  = '0;
                code_nxt = 4'hF;
                if (d == '0) begin
                    state_nxt = IDLE;
                    jam_nxt   = 1'b0;
                end
            end
            DRAIN: begin
                key_nxt  = '0;
                code_nxt = 4'hF;
                jam_nxt  = 1'b0;
                if (d == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                key_nxt   = '0;
                code_nxt  = 4'hF;
                jam_nxt   = 1'b0;
            end
        endcase
    end

    assign Key   = key_q;
    assign Code  = code_q;
    assign Press = press_q;
    assign Jam   = jam_q;

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the lock keypad. It synchronizes the 12 raw key inputs and debounces each one independently. It then applies single-key arbitration, so the virtual-key row generator only ever receives a clean, glitch-free, at-most-one-hot key vector. It sits between the board key pins and the Row_Signal/keypad1 scan path, and drives that path's `Key` input.

## Interface
- N_KEYS, 12, number of key inputs; fixed at 12 for this design.
- DB_CYCLES, 20000, clock cycles a synchronized input must differ from its debounced state before the state flips; legal range ≥2.
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Key_raw  input  12  raw key levels, 1 = pressed, asynchronous to clock.
- Key  output  12  arbitrated key vector, one-hot or all-zero; feeds the row generator.
- Press  output  1  one-cycle pulse when a key is accepted.
- Code  output  4  index (0–11) of the accepted key; 4'hF when none is accepted.
- Jam  output  1  high while a multi-key press is being rejected.

## Operation
- Synchronizer:
  - Two flops per bit on Key_raw give `s[i]`.
- Debounce, per key:
  - Each key has a counter of width clog2(DB_CYCLES) and a debounced state `d[i]`.
  - If s[i]==d[i], the counter clears.
  - Otherwise the counter increments. When the counter equals DB_CYCLES-1 with s[i]!=d[i], d[i] toggles and the counter clears.
  - The counter never wraps; it saturates implicitly because it clears on the toggle.
- Arbitration FSM, states IDLE, HELD, JAM, DRAIN:
  - IDLE: if popcount(d)==1, go to HELD, latch the index into Code, set Key = d, pulse Press. If popcount(d)≥2, go to JAM. If popcount(d)==0, stay.
  - HELD: Key holds the one-hot latched key.
    - Stay while d[Code]==1. Other keys going high while in HELD are ignored and do not change Key or Code.
    - On d[Code]==0: if d==0, go to IDLE; else go to DRAIN.
  - JAM: Jam=1, Key=0, Code=F. Go to IDLE when d==0.
  - DRAIN: Key=0, Code=F, Jam=0. Go to IDLE when d==0.
- Simultaneous events:
  - Two keys whose debounced states rise on the same cycle are treated as a multi-key press and go to JAM, never to HELD.
  - A second key rising on the same cycle the held key falls gives DRAIN.
- A key accepted from IDLE requires d to return to all-zero before any new acceptance, so there is no key rollover.
- Outputs are registered, and Key, Code and Press update together.
- Reset (asserted, any time, including mid-debounce or while in HELD):
  - Sync flops, d and counters go to 0.
  - FSM goes to IDLE.
  - Outputs: Key=0, Code=4'hF, Press=0, Jam=0.

## Timing
- Press latency: with Key_raw[i] stable high from the sampling edge E0 (the first edge that samples the new level), Press and Key[i] are high after edge E0+DB_CYCLES+2. That is 2 edges for sync, DB_CYCLES for debounce, and 1 for the FSM register.
- Release latency: Key clears DB_CYCLES+2 edges after the release is first sampled.
- Glitches: any input pulse or bounce shorter than DB_CYCLES consecutive synchronized cycles produces no change on Key, Press or Jam.
- Press is exactly one cycle per accepted key. It never repeats while the key is held.
- Reset deassertion: the first flop update happens on the first clock rising edge after reset goes high. No output changes before 2+DB_CYCLES+1 edges.

## Test plan
- DB_CYCLES=4 for all scenarios.
- Clean press: Key_raw=12'h010 held 20 cycles, then 0 → Press one pulse 7 edges after the first sample; Key=12'h010, Code=4 until 7 edges after release; then Key=0, Code=F.
- Bounce: Key_raw[3] toggles every 2 cycles for 16 cycles, then stays high → no Press during toggling; Press fires once, 7 edges after the final stable rising edge; Code=3.
- Simultaneous: Key_raw=12'h006 asserted on the same edge → Jam=1, Key=0, Press never fires; Jam clears when both are released and d==0.
- Rollover rejection: press key 0 (accepted, Code=0), then press key 11 while holding 0, then release 0 → Key stays 12'h001 until key 0 releases, then DRAIN with Key=0; no Press for key 11 until both are released and key 11 is re-pressed.
- Reset mid-hold: in HELD with Code=7, drive reset=0 for 1 cycle → Key=0, Code=F, Jam=0 immediately (asynchronous); with key 7 still held after reset, Press re-fires 7 edges later.
- Sub-threshold pulse: Key_raw[9] high for exactly 3 synchronized cycles → no Press, Key stays 0, counter returns to 0.
